lfsr_checker: RTL and testbench
===============================

// Module: lfsr_checker
// PURPOSE
//  Serial PRBS checker for the 4-bit LFSR generator's output stream (generator STATE[0]).
//  Self-synchronises to the incoming stream, declares lock, then counts bit errors.
//  Recurrence checked: s[n+4] = s[n+1] ^ s[n], i.e. x^4+x+1, period 15.
//  Sits at the receive end of a link or loopback; samples on the generator's divided-clock strobe.
// PARAMETERS
//  LOCK_CNT     8  consecutive good bits needed to assert LOCKED
//  LOSS_THRESH  3  consecutive bad bits that force a return to SYNC
//  CNT_W        8  width of ERR_CNT and BIT_CNT (both saturating)
// PORTS
//  clk      in   1      system clock, rising edge
//  RST      in   1      asynchronous, active-low reset
//  EN       in   1      bit-valid strobe; DIN is sampled only when EN=1
//  DIN      in   1      received serial bit
//  CLR      in   1      synchronous clear of ERR_CNT/BIT_CNT
//  LOCKED   out  1      checker locked to the stream
//  ERR      out  1      one-cycle pulse per mismatched bit
//  ERR_CNT  out  CNT_W  mismatches since reset/CLR, saturating
//  BIT_CNT  out  CNT_W  bits compared in CHECK since reset/CLR, saturating
//  HIST     out  4      last 4 bits, newest in [3] (equals generator STATE 3 steps back)
// BEHAVIOUR
//  - Reset (RST=0, async): FSM=SYNC, HIST=0, sync_cnt=0, good/bad runs=0, LOCKED=0, ERR=0, ERR_CNT=0, BIT_CNT=0.
//  - All registers are clocked on clk; the FSM and HIST change only on cycles with EN=1.
//  - Every output is registered. Its value is visible the cycle after the EN sample.
//  - ERR=0 on any cycle without a mismatch, including all EN=0 cycles.
//  - SYNC state:
//    - On EN: HIST <= {DIN, HIST[3:1]}; sync_cnt increments, saturating at 4.
//    - When sync_cnt=4 and the updated HIST != 0, go to CHECK with good_run=0 and bad_run=0.
//    - An all-zero HIST never enters CHECK. This is the lock-up stream, and the FSM stays in SYNC.
//    - No comparison, ERR, or counting happens in SYNC.
//  - CHECK state:
//    - On EN: exp = HIST[1]^HIST[0]. BIT_CNT++.
//    - Shift-in bit = DIN when LOCKED=0; shift-in bit = exp when LOCKED=1 (flywheel).
//      With the flywheel, a single flipped bit costs exactly one error.
//    - Match (DIN==exp): bad_run=0; good_run++ (saturating at LOCK_CNT); LOCKED<=1 when good_run reaches LOCK_CNT.
//    - Mismatch: ERR pulse; ERR_CNT++; bad_run++; good_run=0. LOCKED is unchanged until loss.
//    - bad_run reaches LOSS_THRESH: go to SYNC the same EN cycle.
//      LOCKED<=0; sync_cnt=0; HIST <= {DIN, HIST[3:1]}.
//      ERR_CNT and BIT_CNT are held, not cleared.
//  - Counters: increment only when below 2^CNT_W-1, then hold.
//  - CLR=1: ERR_CNT and BIT_CNT <= 0 and that cycle's increments are discarded.
//    FSM, HIST, and ERR still process a simultaneous EN bit normally.
//  - RST asserted mid-operation: all outputs go to reset values immediately, regardless of clk or EN.
//    After release, resync starts from SYNC.
//  - Latency from the first valid bit:
//    - CHECK is entered after 4 EN bits.
//    - LOCKED rises after 4+LOCK_CNT error-free EN bits (12 by default).
// TESTING
//  1. Seed 4'b1000; feed 40 stream bits on EN every 4th clk -> LOCKED rises after EN #12; ERR never pulses; ERR_CNT=0; BIT_CNT=36.
//  2. Locked; invert one bit (bit #20) -> exactly one ERR pulse; ERR_CNT=1; LOCKED stays 1; no further errors.
//  3. DIN=0 for 30 EN bits -> FSM stays in SYNC; LOCKED=0; ERR_CNT=0; BIT_CNT=0.
//  4. Locked; switch DIN to a stream with 3 consecutive mismatches -> 3 ERR pulses; LOCKED=0 after the 3rd; clean stream then relocks after 12 bits; ERR_CNT=3.
//  5. Force ERR_CNT to 255 with CNT_W=8 -> holds at 255. CLR and a mismatching EN on the same cycle -> ERR_CNT=0 and ERR pulses.
//  6. Locked; pull RST low between clk edges -> LOCKED/ERR_CNT/BIT_CNT/HIST read 0 before the next edge; relock proceeds after release.

Source files
------------

// File: rtl/lfsr_checker.sv
// Serial checker for the x^4+x+1 PRBS stream: self-syncs, locks after LOCK_CNT good bits, counts errors.
// All outputs registered (visible the cycle after the EN sample); no backpressure, EN qualifies DIN.
module lfsr_checker #(
   parameter int LOCK_CNT    = 8,
   parameter int LOSS_THRESH = 3,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             RST,
   input  logic             EN,
   input  logic             DIN,
   input  logic             CLR,
   output logic             LOCKED,
   output logic             ERR,
   output logic [CNT_W-1:0] ERR_CNT,
   output logic [CNT_W-1:0] BIT_CNT,
   output logic [3:0]       HIST
);
   localparam int RUN_MAX = (LOCK_CNT > LOSS_THRESH) ? LOCK_CNT : LOSS_THRESH;
   localparam int RUN_W   = $clog2(RUN_MAX + 1);

   typedef enum logic {SYNC, CHECK} state_t;

   state_t           state_q, state_d;
   logic [3:0]       hist_q, hist_d;
   logic [2:0]       sync_cnt_q, sync_cnt_d;
   logic [RUN_W-1:0] good_run_q, good_run_d;
   logic [RUN_W-1:0] bad_run_q, bad_run_d;
   logic             locked_q, locked_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic             exp_bit;
   logic             err_inc;
   logic             bit_inc;

   always_comb begin
      state_d    = state_q;
      hist_d     = hist_q;
      sync_cnt_d = sync_cnt_q;
      good_run_d = good_run_q;
      bad_run_d  = bad_run_q;
      locked_d   = locked_q;
      err_d      = 1'b0;
      err_inc    = 1'b0;
      bit_inc    = 1'b0;
      exp_bit    = hist_q[1] ^ hist_q[0];

      if (EN) begin
         case (state_q)
            SYNC: begin
               hist_d = {DIN, hist_q[3:1]};
               if (sync_cnt_q != 3'd4) sync_cnt_d = sync_cnt_q + 3'd1;
               // An all-zero window is the LFSR lock-up state and can never be checked.
               if (sync_cnt_d == 3'd4 && hist_d != 4'd0) begin
                  state_d    = CHECK;
                  good_run_d = '0;
                  bad_run_d  = '0;
               end
            end
            default: begin
               bit_inc = 1'b1;
               if (DIN == exp_bit) begin
                  hist_d    = {DIN, hist_q[3:1]};
                  bad_run_d = '0;
                  if (good_run_q != RUN_W'(LOCK_CNT)) good_run_d = good_run_q + RUN_W'(1);
                  if (good_run_d == RUN_W'(LOCK_CNT)) locked_d = 1'b1;
               end else begin
                  err_d      = 1'b1;
                  err_inc    = 1'b1;
                  good_run_d = '0;
                  bad_run_d  = bad_run_q + RUN_W'(1);
                  // Once locked, keep the predicted bit so a lone flip costs one error.
                  hist_d     = {(locked_q ? exp_bit : DIN), hist_q[3:1]};
                  if (bad_run_d == RUN_W'(LOSS_THRESH)) begin
                     state_d    = SYNC;
                     locked_d   = 1'b0;
                     sync_cnt_d = 3'd0;
                     hist_d     = {DIN, hist_q[3:1]};
                  end
               end
            end
         endcase
      end
   end

   always_comb begin
      err_cnt_d = err_cnt_q;
      bit_cnt_d = bit_cnt_q;
      if (CLR) begin
         err_cnt_d = '0;
         bit_cnt_d = '0;
      end else begin
         if (err_inc && err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
         if (bit_inc && bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         state_q    <= SYNC;
         hist_q     <= '0;
         sync_cnt_q <= '0;
         good_run_q <= '0;
         bad_run_q  <= '0;
         locked_q   <= 1'b0;
         err_q      <= 1'b0;
         err_cnt_q  <= '0;
         bit_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         hist_q     <= hist_d;
         sync_cnt_q <= sync_cnt_d;
         good_run_q <= good_run_d;
         bad_run_q  <= bad_run_d;
         locked_q   <= locked_d;
         err_q      <= err_d;
         err_cnt_q  <= err_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
      end
   end

   assign LOCKED  = locked_q;
   assign ERR     = err_q;
   assign ERR_CNT = err_cnt_q;
   assign BIT_CNT = bit_cnt_q;
   assign HIST    = hist_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Randomized bench for lfsr_checker against a queue-based behavioural model of the checker rules.
module tb_lfsr_checker;
   localparam int LOCK_CNT    = 8;
   localparam int LOSS_THRESH = 3;
   localparam int CNT_W       = 8;
   localparam int CNT_MAX     = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst;
   logic             en;
   logic             din;
   logic             clr;
   logic             locked;
   logic             err;
   logic [CNT_W-1:0] err_cnt;
   logic [CNT_W-1:0] bit_cnt;
   logic [3:0]       hist;

   lfsr_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_THRESH(LOSS_THRESH), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .RST     (rst),
      .EN      (en),
      .DIN     (din),
      .CLR     (clr),
      .LOCKED  (locked),
      .ERR     (err),
      .ERR_CNT (err_cnt),
      .BIT_CNT (bit_cnt),
      .HIST    (hist)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: a window of the last four accepted bits, oldest first.
   bit win[$];
   bit m_check, m_locked, m_err;
   int m_sync, m_good, m_bad, m_errs, m_bits;
   int err_pulses;
   logic [3:0] g;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic m_reset();
      win = '{1'b0, 1'b0, 1'b0, 1'b0};
      m_check = 0; m_locked = 0; m_err = 0;
      m_sync = 0; m_good = 0; m_bad = 0; m_errs = 0; m_bits = 0;
   endtask

   function automatic logic [3:0] m_hist();
      return {win[3], win[2], win[1], win[0]};
   endfunction

   task automatic model(input bit e, input bit d, input bit c);
      bit expb, sh, inc_e, inc_b;
      m_err = 0; inc_e = 0; inc_b = 0;
      if (e) begin
         if (!m_check) begin
            win.push_back(d); void'(win.pop_front());
            if (m_sync < 4) m_sync++;
            if (m_sync == 4 && (win[0] | win[1] | win[2] | win[3])) begin
               m_check = 1; m_good = 0; m_bad = 0;
            end
         end else begin
            expb  = win[0] ^ win[1];
            inc_b = 1;
            if (d == expb) begin
               m_bad = 0;
               if (m_good < LOCK_CNT) m_good++;
               if (m_good == LOCK_CNT) m_locked = 1;
               sh = d;
            end else begin
               m_err = 1; inc_e = 1; m_good = 0; m_bad++;
               sh = m_locked ? expb : d;
               if (m_bad == LOSS_THRESH) begin
                  m_check = 0; m_locked = 0; m_sync = 0; sh = d;
               end
            end
            win.push_back(sh); void'(win.pop_front());
         end
      end
      if (c) begin
         m_errs = 0; m_bits = 0;
      end else begin
         if (inc_e && m_errs < CNT_MAX) m_errs++;
         if (inc_b && m_bits < CNT_MAX) m_bits++;
      end
   endtask

   task automatic check_all();
      check("LOCKED", locked, m_locked);
      check("ERR", err, m_err);
      check("ERR_CNT", err_cnt, m_errs);
      check("BIT_CNT", bit_cnt, m_bits);
      check("HIST", hist, m_hist());
   endtask

   // Called at a falling edge; applies inputs across one rising edge and checks at the next fall.
   task automatic step(input bit e, input bit d, input bit c);
      en = e; din = d; clr = c;
      @(posedge clk);
      model(e, d, c);
      @(negedge clk);
      en = 0; clr = 0;
      check_all();
      if (err) err_pulses++;
   endtask

   task automatic gen_bit(output bit b);
      b = g[0];
      g = {g[1] ^ g[0], g[3:1]};
   endtask

   task automatic send(input bit d, input int gap);
      for (int i = 0; i < gap - 1; i++) step(0, 1'b0, 0);
      step(1, d, 0);
   endtask

   task automatic do_reset();
      rst = 0; en = 0; din = 0; clr = 0;
      m_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1;
      err_pulses = 0;
   endtask

   initial begin
      bit b;
      int lock_at;
      rst = 1; en = 0; din = 0; clr = 0;
      m_reset();
      #1 rst = 0;
      #2;
      check_all();
      @(negedge clk);
      rst = 1;

      // Clean stream, EN every 4th clock.
      do_reset();
      g = 4'b1000; lock_at = 0;
      for (int i = 1; i <= 40; i++) begin
         gen_bit(b);
         send(b, 4);
         if (locked && lock_at == 0) lock_at = i;
      end
      check("lock_at", lock_at, 12);
      check("t1_err_pulses", err_pulses, 0);
      check("t1_bit_cnt", bit_cnt, 36);

      // Single flipped bit while locked.
      do_reset();
      g = 4'b1000;
      for (int i = 1; i <= 40; i++) begin
         gen_bit(b);
         send((i == 20) ? ~b : b, 1);
      end
      check("t2_err_pulses", err_pulses, 1);
      check("t2_err_cnt", err_cnt, 1);
      check("t2_locked", locked, 1);

      // All-zero input never leaves SYNC.
      do_reset();
      for (int i = 0; i < 30; i++) send(1'b0, 1 + (i % 2));
      check("t3_locked", locked, 0);
      check("t3_bit_cnt", bit_cnt, 0);

      // Loss of lock after three consecutive mismatches, then relock.
      do_reset();
      g = 4'(1 + $urandom_range(0, 14));
      for (int i = 0; i < 16; i++) begin gen_bit(b); send(b, 1); end
      check("t4_pre_locked", locked, 1);
      for (int i = 0; i < 3; i++) begin gen_bit(b); send(~b, 1); end
      check("t4_err_pulses", err_pulses, 3);
      check("t4_loss", locked, 0);
      for (int i = 0; i < 11; i++) begin gen_bit(b); send(b, 1); end
      check("t4_not_yet", locked, 0);
      gen_bit(b); send(b, 1);
      check("t4_relock", locked, 1);
      check("t4_err_cnt", err_cnt, 3);

      // Saturate ERR_CNT with random data, then CLR against a mismatching bit.
      do_reset();
      for (int i = 0; i < 6000 && m_errs < CNT_MAX; i++) step(1, 1'($urandom), 0);
      for (int i = 0; i < 20; i++) step(1, 1'($urandom), 0);
      check("t5_sat", err_cnt, CNT_MAX);
      for (int i = 0; i < 200 && !m_check; i++) step(1, 1'($urandom), 0);
      check("t5_in_check", m_check, 1);
      step(1, ~(win[0] ^ win[1]), 1);
      check("t5_clr_err", err, 1);
      check("t5_clr_cnt", err_cnt, 0);

      // Asynchronous reset between edges while locked.
      do_reset();
      g = 4'b0110;
      for (int i = 0; i < 14; i++) begin gen_bit(b); send(b, 1); end
      check("t6_pre_locked", locked, 1);
      #2 rst = 0;
      #1;
      check("t6_locked", locked, 0);
      check("t6_err_cnt", err_cnt, 0);
      check("t6_bit_cnt", bit_cnt, 0);
      check("t6_hist", hist, 0);
      m_reset();
      @(negedge clk);
      check_all();
      rst = 1;
      for (int i = 0; i < 12; i++) begin gen_bit(b); send(b, 1); end
      check("t6_relock", locked, 1);

      // Random gaps, occasional flips and clears.
      do_reset();
      g = 4'(1 + $urandom_range(0, 14));
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            gen_bit(b);
            step(1, ($urandom_range(0, 15) == 0) ? ~b : b, $urandom_range(0, 49) == 0);
         end else begin
            step(0, 1'($urandom), $urandom_range(0, 49) == 0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
